noc_control_module_pkt_mux: RTL and testbench
=============================================

NOC_CONTROL_MODULE_PKT_MUX -- requirements
Module: noc_control_module_pkt_mux

Interface
REQ-001 SHALL have parameter NUM_IN, default 2, number of dii_flit packet sources (range 2..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_debug  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port stall  input  1  when high, blocks new packet grants.
REQ-005 SHALL have port in_flit  input  NUM_IN x dii_flit  source flits (valid, last, data[15:0]); index 0 is the utilization stream.
REQ-006 SHALL have port in_ready  output  NUM_IN  per-source accept.
REQ-007 SHALL have port out_flit  output  dii_flit  merged debug packet stream.
REQ-008 SHALL have port out_ready  input  1  downstream accept.
REQ-009 SHALL have port pkt_count  output  16  number of packets fully emitted on out_flit.
REQ-010 SHALL have port busy  output  1  high while a packet is locked or the buffer is non-empty.

Function
REQ-011 SHALL forward whole packets atomically: no flit of another source is interleaved between a granted packet's first flit and its last-flagged flit.
REQ-012 SHALL implement an FSM with two states: IDLE and LOCKED.
REQ-013 IDLE: if stall=0 and any in_flit[i].valid=1, SHALL register grant to the first valid index searching upward from rr_ptr (wrapping) and enter LOCKED next cycle; otherwise stay IDLE.
REQ-014 IDLE SHALL assert no in_ready bit.
REQ-015 LOCKED: in_ready[grant] SHALL equal (buffer count < 2); all other in_ready bits 0.
REQ-016 A flit SHALL be accepted when in_flit[grant].valid and in_ready[grant] are both high; it is pushed into a 2-entry FIFO with valid, last and data unchanged.
REQ-017 On accepting a flit with last=1, the block SHALL return to IDLE and set rr_ptr to (grant+1) mod NUM_IN.
REQ-018 stall SHALL NOT affect a LOCKED packet; it completes normally.
REQ-019 out_flit SHALL be driven from the FIFO head register only; out_flit.valid = FIFO non-empty; out_flit.data/last = 0 when empty.
REQ-020 The FIFO SHALL pop when out_flit.valid and out_ready are both high; push and pop in the same cycle SHALL leave the count unchanged.
REQ-021 in_ready SHALL have no combinational dependence on out_ready, so push into a full FIFO is impossible.
REQ-022 Latency: a flit accepted in cycle t SHALL appear on out_flit in cycle t+1 if the FIFO was empty or popped in t.
REQ-023 Throughput: with out_ready held high, one flit per cycle SHALL be sustained within a packet; one idle arbitration cycle SHALL separate consecutive packets on the input side.
REQ-024 pkt_count SHALL increment by 1 when a flit with last=1 pops, wrapping 0xFFFF -> 0x0000.
REQ-025 busy SHALL be (state == LOCKED) or (FIFO count != 0).
REQ-026 Source valid dropping mid-packet SHALL only pause transfer; the lock SHALL be held until last.

Reset
REQ-027 On rst_debug high, immediately and independent of clk: state IDLE, rr_ptr 0, grant 0, FIFO empty, pkt_count 0, out_flit all-zero, in_ready all 0, busy 0.
REQ-028 Reset asserted mid-packet SHALL discard buffered flits and the partial packet; no flit SHALL be emitted until a new grant after release.

Verification
REQ-029 Single packet: source 0 sends 5 flits (0x0000, 0x0001, 0x8000, 0x0011, 0xABCD last), out_ready=1 -> identical 5 flits on out, first at 2 cycles after valid, pkt_count=1.
REQ-030 Contention: sources 0 and 1 each present 3-flit packets continuously from reset -> output order src0, src1, src0, src1, never interleaved.
REQ-031 Backpressure: out_ready low for 10 cycles mid-packet -> in_ready falls after 2 buffered flits, no flit lost or duplicated, order preserved.
REQ-032 Stall: stall=1 in IDLE with source 1 valid -> no grant, busy=0; stall raised during LOCKED -> packet completes, then no new grant until stall=0.
REQ-033 Reset mid-packet: rst_debug pulsed after 2 of 4 flits accepted -> out_flit.valid=0 same cycle, pkt_count=0, next packet emitted intact.
REQ-034 Wrap: preload 65535 completed packets (or force) -> next packet yields pkt_count=0x0000.

Source files
------------

// File: rtl/noc_control_module_pkt_mux.sv
// Packet-atomic round-robin merge of NUM_IN debug flit sources into one stream,
// buffered through a 2-entry FIFO whose head drives the output directly.
package dii_package;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

module noc_control_module_pkt_mux
    import dii_package::*;
#(
    parameter int unsigned NUM_IN = 2
) (
    input  logic                 clk,
    input  logic                 rst_debug,
    input  logic                 stall,
    input  dii_flit [NUM_IN-1:0] in_flit,
    output logic [NUM_IN-1:0]    in_ready,
    output dii_flit              out_flit,
    input  logic                 out_ready,
    output logic [15:0]          pkt_count,
    output logic                 busy
);
    localparam int unsigned GW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [GW-1:0] LAST_IDX = GW'(NUM_IN - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rr_q, rr_d;
    logic [GW-1:0] req_idx;
    logic          req_found;
    logic [31:0]   scan_idx;
    logic [GW-1:0] scan_sel;

    dii_flit       fifo_q [2];
    logic          rd_q, wr_q;
    logic [1:0]    cnt_q;
    logic [15:0]   pkt_cnt_q;

    dii_flit       cur;
    logic          fifo_full;
    logic          push, pop;

    assign cur       = in_flit[grant_q];
    assign fifo_full = (cnt_q == 2'd2);
    // Accept depends only on registered state, never on out_ready
    assign push      = (state_q == LOCKED) && cur.valid && !fifo_full;
    assign pop       = (cnt_q != 2'd0) && out_ready;

    always_comb begin
        req_found = 1'b0;
        req_idx   = rr_q;
        scan_idx  = '0;
        scan_sel  = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            scan_idx = (32'(rr_q) + i) % NUM_IN;
            scan_sel = GW'(scan_idx);
            if (!req_found && in_flit[scan_sel].valid) begin
                req_found = 1'b1;
                req_idx   = scan_sel;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        in_ready = '0;
        case (state_q)
            IDLE: begin
                if (!stall && req_found) begin
                    grant_d = req_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                in_ready[grant_q] = !fifo_full;
                if (push && cur.last) begin
                    state_d = IDLE;
                    rr_d    = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_debug) begin
        if (rst_debug) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    always_ff @(posedge clk or posedge rst_debug) begin
        if (rst_debug) begin
            for (int unsigned i = 0; i < 2; i++) fifo_q[i] <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            cnt_q     <= '0;
            pkt_cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_q] <= cur;
                wr_q         <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
                if (fifo_q[rd_q].last) pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_comb begin
        out_flit = '0;
        if (cnt_q != 2'd0) begin
            out_flit       = fifo_q[rd_q];
            out_flit.valid = 1'b1;
        end
    end

    assign pkt_count = pkt_cnt_q;
    assign busy      = (state_q == LOCKED) || (cnt_q != 2'd0);

endmodule

// File: tb/tb_noc_control_module_pkt_mux.sv
// Directed bench for noc_control_module_pkt_mux: queue-driven sources, output
// capture, and hand-computed expected flit sequences.
module tb_noc_control_module_pkt_mux;
    import dii_package::*;

    logic          clk = 1'b0;
    logic          rst_debug = 1'b0;
    logic          stall = 1'b0;
    dii_flit [1:0] in_flit = '0;
    logic [1:0]    in_ready;
    dii_flit       out_flit;
    logic          out_ready = 1'b1;
    logic [15:0]   pkt_count;
    logic          busy;

    noc_control_module_pkt_mux #(.NUM_IN(2)) dut (
        .clk       (clk),
        .rst_debug (rst_debug),
        .stall     (stall),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_ready (out_ready),
        .pkt_count (pkt_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [17:0] q0 [$];
    logic [17:0] q1 [$];
    logic [16:0] obs [$];
    logic [16:0] exp_q [$];
    logic [1:0]  pend;
    logic        stall_nxt, ordy_nxt;
    int          cyc, acc0, idle_bad, first_in, first_out, last_out;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic push_flit(input int src, input logic last, input logic [15:0] d, input logic expect_out);
        if (src == 0) q0.push_back({1'b1, last, d});
        else          q1.push_back({1'b1, last, d});
        if (expect_out) exp_q.push_back({last, d});
    endtask

    task automatic clear_tb();
        q0.delete(); q1.delete(); obs.delete(); exp_q.delete();
        pend = '0; acc0 = 0; idle_bad = 0;
        first_in = -1; first_out = -1; last_out = -1;
        stall_nxt = 1'b0; ordy_nxt = 1'b1;
        in_flit = '0; stall = 1'b0; out_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_debug = 1'b1;
        clear_tb();
        repeat (2) @(negedge clk);
        rst_debug = 1'b0;
    endtask

    // Sources are updated once per cycle at the falling edge; a flit counts as
    // taken if valid&ready held when the previous rising edge occurred.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        stall     = stall_nxt;
        out_ready = ordy_nxt;
        if (pend[0] && q0.size() > 0) begin q0.delete(0); acc0++; end
        if (pend[1] && q1.size() > 0) q1.delete(0);
        in_flit = '0;
        if (q0.size() > 0) begin
            in_flit[0] = dii_flit'(q0[0]);
            if (!q0[0][17]) q0.delete(0);
            else if (first_in < 0) first_in = cyc;
        end
        if (q1.size() > 0) begin
            in_flit[1] = dii_flit'(q1[0]);
            if (!q1[0][17]) q1.delete(0);
        end
        #1;
        pend[0] = in_flit[0].valid && in_ready[0];
        pend[1] = in_flit[1].valid && in_ready[1];
        if (out_flit.valid) begin
            if (first_out < 0) first_out = cyc;
            if (out_ready) begin
                obs.push_back({out_flit.last, out_flit.data});
                last_out = cyc;
            end
        end else if (out_flit.last || out_flit.data != 16'h0) begin
            idle_bad++;
        end
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (obs.size() < n && k < budget) begin
            cycle();
            k++;
        end
        if (obs.size() < n) check_eq({tag, "_timeout"}, obs.size(), n);
    endtask

    task automatic cmp_obs(input string tag);
        check_eq({tag, "_count"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs.size()) check_eq($sformatf("%s_flit%0d", tag, i), 32'(obs[i]), 32'(exp_q[i]));
        end
        check_eq({tag, "_idle_zero"}, idle_bad, 0);
    endtask

    initial begin
        cyc = 0;
        clear_tb();

        // Reset state, applied asynchronously before any clock edge
        #1 rst_debug = 1'b1;
        #1;
        check_eq("rst_out_valid", out_flit.valid, 1'b0);
        check_eq("rst_out_flit", 32'(out_flit), 32'h0);
        check_eq("rst_in_ready", in_ready, 2'b00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_pkt_count", pkt_count, 16'h0);
        @(negedge clk);
        rst_debug = 1'b0;

        // Single 5-flit packet from source 0
        push_flit(0, 1'b0, 16'h0000, 1'b1);
        push_flit(0, 1'b0, 16'h0001, 1'b1);
        push_flit(0, 1'b0, 16'h8000, 1'b1);
        push_flit(0, 1'b0, 16'h0011, 1'b1);
        push_flit(0, 1'b1, 16'hABCD, 1'b1);
        run_until(5, 40, "single");
        repeat (2) cycle();
        cmp_obs("single");
        check_eq("single_latency", first_out - first_in, 2);
        check_eq("single_burst", last_out - first_out, 4);
        check_eq("single_pkt_count", pkt_count, 16'd1);
        check_eq("single_busy_end", busy, 1'b0);

        // Contention from reset, with a valid gap inside source 0's first packet
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < 2; s++) begin
                for (int f = 0; f < 3; f++) begin
                    push_flit(s, f == 2, 16'((s << 12) | (p << 8) | f), 1'b1);
                    if (s == 0 && p == 0 && f == 0) q0.push_back(18'h0);
                end
            end
        end
        // src0 pkt0 and src1 pkt0 were pushed interleaved by queue; rebuild
        // expected order explicitly: s0p0, s1p0, s0p1, s1p1
        exp_q.delete();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 2; s++)
                for (int f = 0; f < 3; f++)
                    exp_q.push_back({f == 2, 16'((s << 12) | (p << 8) | f)});
        run_until(12, 80, "contend");
        repeat (2) cycle();
        cmp_obs("contend");
        check_eq("contend_pkt_count", pkt_count, 16'd4);

        // Backpressure: out_ready low for 10 cycles mid-packet
        do_reset();
        for (int f = 0; f < 6; f++) push_flit(0, f == 5, 16'h5A00 + 16'(f), 1'b1);
        run_until(2, 20, "bp_pre");
        ordy_nxt = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (k == 6) begin
                check_eq("bp_in_ready_low", in_ready, 2'b00);
                check_eq("bp_busy", busy, 1'b1);
                check_eq("bp_out_valid", out_flit.valid, 1'b1);
                check_eq("bp_held_count", obs.size(), 2);
            end
        end
        ordy_nxt = 1'b1;
        run_until(6, 40, "bp");
        repeat (4) cycle();
        cmp_obs("bp");
        check_eq("bp_pkt_count", pkt_count, 16'd1);

        // Stall in IDLE blocks grant; stall during LOCKED lets the packet finish
        do_reset();
        stall_nxt = 1'b1;
        push_flit(1, 1'b0, 16'h1100, 1'b1);
        push_flit(1, 1'b1, 16'h1101, 1'b1);
        repeat (5) cycle();
        check_eq("stall_idle_busy", busy, 1'b0);
        check_eq("stall_idle_ready", in_ready, 2'b00);
        check_eq("stall_idle_out", out_flit.valid, 1'b0);
        stall_nxt = 1'b0;
        for (int k = 0; k < 10 && !in_ready[1]; k++) cycle();
        check_eq("stall_grant1", in_ready, 2'b10);
        stall_nxt = 1'b1;
        push_flit(0, 1'b0, 16'h0A00, 1'b0);
        push_flit(0, 1'b1, 16'h0A01, 1'b0);
        run_until(2, 20, "stall_lock");
        repeat (5) cycle();
        cmp_obs("stall_lock");
        check_eq("stall_no_regrant_busy", busy, 1'b0);
        check_eq("stall_no_regrant_ready", in_ready, 2'b00);
        exp_q.push_back({1'b0, 16'h0A00});
        exp_q.push_back({1'b1, 16'h0A01});
        stall_nxt = 1'b0;
        run_until(4, 20, "stall_rel");
        repeat (2) cycle();
        cmp_obs("stall_rel");
        check_eq("stall_pkt_count", pkt_count, 16'd2);

        // Reset pulsed after 2 of 4 flits accepted
        do_reset();
        for (int f = 0; f < 4; f++) push_flit(0, f == 3, 16'h7700 + 16'(f), 1'b0);
        for (int k = 0; k < 20 && acc0 < 2; k++) cycle();
        check_eq("rmid_accepted", acc0, 2);
        check_eq("rmid_pre_valid", out_flit.valid, 1'b1);
        #1 rst_debug = 1'b1;
        #1;
        check_eq("rmid_out_valid", out_flit.valid, 1'b0);
        check_eq("rmid_pkt_count", pkt_count, 16'h0);
        check_eq("rmid_busy", busy, 1'b0);
        @(negedge clk);
        rst_debug = 1'b0;
        clear_tb();
        repeat (3) cycle();
        check_eq("rmid_quiet", obs.size(), 0);
        for (int f = 0; f < 3; f++) push_flit(1, f == 2, 16'h3300 + 16'(f), 1'b1);
        run_until(3, 30, "rmid_next");
        repeat (3) cycle();
        cmp_obs("rmid_next");
        check_eq("rmid_next_pkt_count", pkt_count, 16'd1);

        // pkt_count wrap from 0xFFFF
        do_reset();
        cycle();
        force dut.pkt_cnt_q = 16'hFFFF;
        #1 release dut.pkt_cnt_q;
        cycle();
        check_eq("wrap_preload", pkt_count, 16'hFFFF);
        push_flit(0, 1'b1, 16'hBEEF, 1'b1);
        run_until(1, 20, "wrap");
        repeat (2) cycle();
        cmp_obs("wrap");
        check_eq("wrap_pkt_count", pkt_count, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
